// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with a one-entry valid/ready
// holding register.
//
// Frame format is configurable: DATA_BITS data bits (LSB first), optional
// odd/even parity, one or two stop bits. The raw rxd pin is synchronised
// internally. Line breaks are detected and reported. A completed frame that
// finds the holding register still occupied is dropped and reported as an
// overrun.
//
// Parameters
//   CLK_PER_HALF_BIT  clk cycles per half bit period (>= 4)
//   DATA_BITS         data bits per frame, 5..9
//   PARITY            0 = none, 1 = odd, 2 = even
//   STOP_BITS         1 or 2
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   rxd          in   raw serial line, idle high, asynchronous to clk
//   rdata        out  received word, valid while rdata_valid
//   rdata_valid  out  holding register full
//   rdata_ready  in   consumer accepts rdata when rdata_valid && rdata_ready
//   perr         out  1-cycle pulse: parity mismatch on the delivered word
//   ferr         out  1-cycle pulse: a stop bit was sampled low
//   brk          out  1-cycle pulse: break (all-zero frame including stop)
//   oerr         out  1-cycle pulse: completed frame dropped, register full
module uart_rx_cfg #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic                 perr,
  output logic                 ferr,
  output logic                 brk,
  output logic                 oerr
);

  localparam logic [31:0] HALF_LAST = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] FULL_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state;
  logic [31:0]          cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_bad;
  logic                 rx_p0;
  logic                 rx_p1;
  logic                 rxs;

  assign rxs = rx_p1;

  // True when the received parity bit disagrees with the configured mode.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                      input logic p);
    if (PARITY == 1)      return ~(^d ^ p);
    else if (PARITY == 2) return (^d ^ p);
    else                  return 1'b0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0       <= 1'b1;
      rx_p1       <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      stop_bad    <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      brk         <= 1'b0;
      oerr        <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchroniser on the raw line
      rx_p0 <= rxd;
      rx_p1 <= rx_p0;

      perr <= 1'b0;
      ferr <= 1'b0;
      brk  <= 1'b0;
      oerr <= 1'b0;

      // Consumer handshake; a load later in this block takes precedence.
      if (rdata_valid && rdata_ready) rdata_valid <= 1'b0;

      cnt <= cnt + 32'd1;

      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_bad <= 1'b0;
          par_bit  <= 1'b0;
          if (!rxs) state <= S_START;
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // A line already back high at mid start bit was a glitch.
            if (rxs) state <= S_IDLE;
            else     state <= S_DATA;
          end
        end

        S_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            // Shifting in at the MSB end leaves the first bit at the LSB.
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end

        S_PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (bit_idx != STOP_LAST) begin
              bit_idx  <= bit_idx + 4'd1;
              stop_bad <= stop_bad | ~rxs;
            end else if (shreg == '0 && (PARITY == 0 || !par_bit) && !rxs) begin
              // Break: wait for the line to recover before looking for a start.
              brk   <= 1'b1;
              ferr  <= 1'b1;
              state <= S_WAIT_HIGH;
            end else if (stop_bad || !rxs) begin
              ferr  <= 1'b1;
              state <= S_IDLE;
            end else begin
              // Returning to IDLE now lets the second half of the stop bit
              // already catch the next start edge.
              state <= S_IDLE;
              if (!rdata_valid || rdata_ready) begin
                rdata       <= shreg;
                rdata_valid <= 1'b1;
                perr        <= parity_bad(shreg, par_bit);
              end else begin
                oerr <= 1'b1;
              end
            end
          end
        end

        S_WAIT_HIGH: begin
          cnt <= '0;
          if (rxs) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
